// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter for the shared single-cycle data memory port, with memory dump sequencing.
// Define DMA_ADDR_CHECK_EN to reject accesses at or beyond MEM_WORDS (addr_err instead of a memory access).
module data_mem_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 64,
    parameter int MEM_WORDS    = 15451,
    parameter int SAVE_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        addr_err,
    input  logic                        save_req,
    output logic                        save_done,
    output logic                        save_err,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_inputData,
    output logic                        mem_writeEnable,
    output logic                        mem_save,
    input  logic [DATA_W-1:0]           mem_out,
    input  logic                        mem_done_saving
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ACCESS     = 3'd1;
    localparam logic [2:0] S_RESP       = 3'd2;
    localparam logic [2:0] S_SAVE_PULSE = 3'd3;
    localparam logic [2:0] S_SAVE_WAIT  = 3'd4;

`ifdef DMA_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

    logic [2:0]        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  cur_idx;
    logic              cur_we;
    logic              cur_oob;
    logic [15:0]       save_cnt;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;
    logic              pick_oob;

    // Search starts just after the last winner, so a held request drops to lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign pick_addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
    assign pick_wdata = req_wdata[pick_idx*DATA_W +: DATA_W];
    assign pick_oob   = ADDR_CHECK && ({1'b0, pick_addr} >= MEM_LIMIT);

    assign mem_writeEnable = (state == S_ACCESS) && cur_we && !cur_oob;
    assign mem_save        = (state == S_SAVE_PULSE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            rr_ptr        <= IDX_W'(NUM_REQ - 1);
            cur_idx       <= '0;
            cur_we        <= 1'b0;
            cur_oob       <= 1'b0;
            save_cnt      <= '0;
            grant         <= '0;
            rvalid        <= '0;
            rdata         <= '0;
            addr_err      <= 1'b0;
            save_done     <= 1'b0;
            save_err      <= 1'b0;
            mem_address   <= '0;
            mem_inputData <= '0;
        end else begin
            grant     <= '0;
            rvalid    <= '0;
            addr_err  <= 1'b0;
            save_done <= 1'b0;
            save_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Timeout is counted from the mem_save cycle, hence the load on entry.
                    if (save_req) begin
                        save_cnt <= 16'(SAVE_TIMEOUT);
                        state    <= S_SAVE_PULSE;
                    end else if (pick_valid) begin
                        grant         <= NUM_REQ'(1) << pick_idx;
                        rr_ptr        <= pick_idx;
                        cur_idx       <= pick_idx;
                        cur_we        <= req_we[pick_idx];
                        cur_oob       <= pick_oob;
                        mem_address   <= pick_oob ? '0 : pick_addr;
                        mem_inputData <= pick_wdata;
                        state         <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    rdata <= cur_oob ? '0 : (cur_we ? mem_inputData : mem_out);
                    state <= S_RESP;
                end
                S_RESP: begin
                    rvalid   <= NUM_REQ'(1) << cur_idx;
                    addr_err <= cur_oob;
                    state    <= S_IDLE;
                end
                S_SAVE_PULSE: begin
                    save_cnt <= (save_cnt == 16'd0) ? 16'd0 : save_cnt - 16'd1;
                    state    <= S_SAVE_WAIT;
                end
                S_SAVE_WAIT: begin
                    if (mem_done_saving) begin
                        save_done <= 1'b1;
                        state     <= S_IDLE;
                    end else if (save_cnt <= 16'd1) begin
                        save_cnt  <= 16'd0;
                        save_done <= 1'b1;
                        save_err  <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        save_cnt <= save_cnt - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed and random accesses against a transaction-level model
// of round-robin order and memory contents, plus save and reset sequences.
module tb_data_mem_arbiter;

    localparam int N       = 4;
    localparam int AW      = 16;
    localparam int DW      = 64;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N-1:0]      req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      grant;
    logic [N-1:0]      rvalid;
    logic [DW-1:0]     rdata;
    logic              addr_err;
    logic              save_req;
    logic              save_done;
    logic              save_err;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_inputData;
    logic              mem_writeEnable;
    logic              mem_save;
    logic [DW-1:0]     mem_out;
    logic              mem_done_saving;

    int errors = 0;
    int checks = 0;
    int unsigned model_ptr;
    logic [63:0] ref_mem [int];
    logic [DW-1:0] env_mem [0:65535];

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(15451), .SAVE_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .grant(grant), .rvalid(rvalid), .rdata(rdata),
        .addr_err(addr_err), .save_req(save_req), .save_done(save_done),
        .save_err(save_err), .mem_address(mem_address), .mem_inputData(mem_inputData),
        .mem_writeEnable(mem_writeEnable), .mem_save(mem_save), .mem_out(mem_out),
        .mem_done_saving(mem_done_saving)
    );

    function automatic logic [63:0] init_word(input logic [15:0] a);
        if (a == 16'h0010) return 64'h0123456789ABCDEF;
        return {a, ~a, a ^ 16'h5A5A, 16'hC0DE};
    endfunction

    // Memory the DUT talks to: combinational read, write on the rising edge.
    initial for (int a = 0; a < 65536; a++) env_mem[a] = init_word(16'(a));
    always @(posedge clk) if (mem_writeEnable) env_mem[mem_address] = mem_inputData;
    assign mem_out = env_mem[mem_address];

    function automatic logic [63:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    // Rotate the request mask so the requester after the last winner sits at bit 0.
    function automatic int unsigned model_pick(input logic [N-1:0] mask, input int unsigned ptr);
        logic [2*N-1:0] dbl = {mask, mask};
        logic [N-1:0]   rot = N'(dbl >> ((ptr + 1) % N));
        for (int b = 0; b < N; b++) if (rot[b]) return (ptr + 1 + b) % N;
        return 0;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int i, input logic we, input logic [15:0] a, input logic [63:0] d);
        req[i]                 = 1'b1;
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    // Called in an IDLE cycle with requests applied; returns in the following IDLE cycle.
    task automatic run_access(input int unsigned who, input logic we, input logic [15:0] addr,
                              input logic [63:0] wd, input logic drop);
        logic [63:0]  exp = we ? wd : ref_read(addr);
        logic [N-1:0] oh  = N'(1) << who;
        if (we) ref_mem[int'(addr)] = wd;
        step();
        check_output("grant", 64'(grant), 64'(oh));
        check_output("access_we", 64'(mem_writeEnable), 64'(we));
        check_output("access_addr", 64'(mem_address), 64'(addr));
        if (we) check_output("access_wdata", mem_inputData, wd);
        if (drop) req[who] = 1'b0;
        step();
        check_output("resp_grant", 64'(grant), 64'd0);
        check_output("resp_we", 64'(mem_writeEnable), 64'd0);
        check_output("resp_rdata", rdata, exp);
        step();
        check_output("rvalid", 64'(rvalid), 64'(oh));
        check_output("rvalid_rdata", rdata, exp);
        check_output("addr_err", 64'(addr_err), 64'd0);
        check_output("idle_grant", 64'(grant), 64'd0);
        model_ptr = who;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int unsigned w;
        int quiet;
        logic [N-1:0] mask;
        logic [15:0] rr_addr [N];

        rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        save_req = 1'b0; mem_done_saving = 1'b0;
        #1;
        check_output("rst_grant", 64'(grant), 64'd0);
        check_output("rst_rvalid", 64'(rvalid), 64'd0);
        check_output("rst_rdata", rdata, 64'd0);
        check_output("rst_we", 64'(mem_writeEnable), 64'd0);
        check_output("rst_save", 64'(mem_save), 64'd0);
        check_output("rst_save_done", 64'(save_done), 64'd0);
        check_output("rst_addr", 64'(mem_address), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_ptr = N - 1;

        // All requesters held: requester 1 reads the 0x0010 word.
        for (int i = 0; i < N; i++) begin
            rr_addr[i] = (i == 1) ? 16'h0010 : 16'(16'h0020 + i);
            apply_stimulus(i, 1'b0, rr_addr[i], 64'd0);
        end
        for (int r = 0; r < 5; r++) begin
            w = model_pick(req, model_ptr);
            run_access(w, 1'b0, rr_addr[w], 64'd0, 1'b0);
        end
        req = '0;

        apply_stimulus(0, 1'b1, 16'h0200, 64'hDEADBEEFCAFEF00D);
        run_access(model_pick(req, model_ptr), 1'b1, 16'h0200, 64'hDEADBEEFCAFEF00D, 1'b1);
        apply_stimulus(2, 1'b0, 16'h0200, 64'd0);
        run_access(model_pick(req, model_ptr), 1'b0, 16'h0200, 64'd0, 1'b1);

        apply_stimulus(3, 1'b0, 16'h3C5B, 64'd0);
        run_access(model_pick(req, model_ptr), 1'b0, 16'h3C5B, 64'd0, 1'b1);

        for (int r = 0; r < 20; r++) begin
            req  = '0;
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                if (mask[i]) apply_stimulus(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                                            {$urandom, $urandom});
            w = model_pick(mask, model_ptr);
            run_access(w, req_we[w], req_addr[w*AW +: AW], req_wdata[w*DW +: DW], 1'b0);
        end
        req = '0;

        save_req = 1'b1;
        apply_stimulus(3, 1'b0, 16'h0005, 64'd0);
        step();
        check_output("save_pulse", 64'(mem_save), 64'd1);
        check_output("save_no_grant", 64'(grant), 64'd0);
        quiet = 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (k == 1) check_output("save_pulse_len", 64'(mem_save), 64'd0);
            if (grant != '0 || save_done || rvalid != '0) quiet++;
        end
        check_output("save_wait_quiet", 64'(quiet), 64'd0);
        mem_done_saving = 1'b1;
        step();
        check_output("save_done", 64'(save_done), 64'd1);
        check_output("save_err_clear", 64'(save_err), 64'd0);
        mem_done_saving = 1'b0;
        save_req = 1'b0;
        run_access(model_pick(req, model_ptr), 1'b0, 16'h0005, 64'd0, 1'b1);

        save_req = 1'b1;
        step();
        check_output("tmo_pulse", 64'(mem_save), 64'd1);
        save_req = 1'b0;
        quiet = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            step();
            if (save_done || save_err) quiet++;
        end
        check_output("tmo_early", 64'(quiet), 64'd0);
        step();
        check_output("tmo_done", 64'(save_done), 64'd1);
        check_output("tmo_err", 64'(save_err), 64'd1);
        step();
        check_output("tmo_done_pulse", 64'(save_done), 64'd0);
        check_output("tmo_err_pulse", 64'(save_err), 64'd0);

        apply_stimulus(1, 1'b1, 16'h0300, 64'h1122334455667788);
        step();
        check_output("rstacc_grant", 64'(grant), 64'(N'(1) << model_pick(4'b0010, model_ptr)));
        check_output("rstacc_we", 64'(mem_writeEnable), 64'd1);
        req = '0;
        #2 rst = 1'b1;
        #1;
        check_output("rstacc_we_drop", 64'(mem_writeEnable), 64'd0);
        check_output("rstacc_addr", 64'(mem_address), 64'd0);
        check_output("rstacc_wdata", mem_inputData, 64'd0);
        check_output("rstacc_rdata", rdata, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_ptr = N - 1;
        quiet = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (rvalid != '0 || mem_writeEnable) quiet++;
        end
        check_output("rstacc_no_rvalid", 64'(quiet), 64'd0);
        apply_stimulus(1, 1'b0, 16'h0300, 64'd0);
        run_access(model_pick(req, model_ptr), 1'b0, 16'h0300, 64'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Round-robin arbiter sharing the single-cycle data memory port A (16-bit address, 64-bit data, combinational read) among NUM_REQ requesters, such as image-processing cores.
- Registers each winner's command, drives the memory for exactly one cycle and returns the registered read data.
- Also sequences the memory's save/doneSaving dump, blocking traffic while it runs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 16, memory address width
DATA_W, 64, memory word width
MEM_WORDS, 15451, valid word count; used only with DMA_ADDR_CHECK_EN
SAVE_TIMEOUT, 1024, max cycles to wait for mem_done_saving

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req  in  NUM_REQ  per-requester request, held until grant
req_we  in  NUM_REQ  per-requester write enable (1=write, 0=read)
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
grant  out  NUM_REQ  one-hot, one-cycle pulse: command accepted
rvalid  out  NUM_REQ  one-hot, one-cycle pulse: rdata valid for that requester
rdata  out  DATA_W  shared registered read/write-echo data
addr_err  out  1  one-cycle pulse, out-of-range access (DMA_ADDR_CHECK_EN only, else tied 0)
save_req  in  1  level request to dump memory
save_done  out  1  one-cycle pulse, save finished
save_err  out  1  one-cycle pulse with save_done on timeout
mem_address  out  ADDR_W  to memory address
mem_inputData  out  DATA_W  to memory inputData
mem_writeEnable  out  1  to memory writeEnable
mem_save  out  1  to memory save
mem_out  in  DATA_W  from memory out
mem_done_saving  in  1  from memory doneSaving

Behaviour:
- Reset (async, immediate): state IDLE, rr_ptr=NUM_REQ-1, every output 0; mem_writeEnable drops at once, even mid-ACCESS.
- FSM states: IDLE, ACCESS, RESP, SAVE_PULSE, SAVE_WAIT.
- IDLE:
  - save_req=1 -> SAVE_PULSE; save has priority over req.
  - else any req -> pick first set bit searching rr_ptr+1 upward, mod NUM_REQ.
  - On pick: latch that requester's index, we, addr and wdata; pulse grant[i]; rr_ptr<=i; go ACCESS.
  - else stay.
- ACCESS (1 cycle):
  - mem_address/mem_inputData driven from latched registers; mem_writeEnable=latched we.
  - Capture rdata: mem_out on read, latched wdata on write. Go RESP.
- RESP (1 cycle): rvalid[i]=1, rdata stable, mem_writeEnable=0 -> IDLE.
- Latency: grant at cycle t+1 after req sampled at t; rvalid at t+3. Peak throughput is one access per 3 cycles.
- Requester may drop req in the grant cycle. If req stays high, it re-arbitrates in the next IDLE as lowest priority.
- A req dropped before grant is simply withdrawn; no access occurs.
- Outside ACCESS: mem_writeEnable=0; mem_address/mem_inputData hold last value.
- rdata holds until the next capture.
- SAVE_PULSE (1 cycle): mem_save=1; load 16-bit timeout counter with SAVE_TIMEOUT -> SAVE_WAIT.
- SAVE_WAIT:
  - mem_save=0, no grants.
  - mem_done_saving=1 -> save_done pulse -> IDLE.
  - counter reaching 0 -> save_done+save_err pulse -> IDLE.
- save_req sampled only in IDLE; a request arriving mid-access is serviced after RESP.
- save_req must drop before save_done+1, or a new save starts.

Optional Feature:
DMA_ADDR_CHECK_EN:
- Defined:
  - In IDLE, a winner with addr>=MEM_WORDS is still granted.
  - ACCESS forces mem_writeEnable=0 and mem_address=0, and captures rdata=0.
  - RESP pulses rvalid[i] together with addr_err.
- Undefined: address is forwarded unchanged and addr_err is tied 0.

Test Plan:
- Requester 1 read, addr 0x0010, mem holds 0x0123456789ABCDEF -> grant=0010 at t+1; rvalid=0010 with rdata=0x0123456789ABCDEF at t+3.
- All 4 req held high continuously from reset -> grant order 0,1,2,3,0, each grant 3 cycles apart; no requester granted twice before the others.
- Req0 writes 0xDEADBEEFCAFEF00D to 0x0200, then req2 reads 0x0200 -> one-cycle mem_writeEnable pulse; req2 rdata=0xDEADBEEFCAFEF00D.
- save_req and req3 asserted together in IDLE -> mem_save pulse, no grant. Memory model raises done after 50 cycles -> save_done; req3 granted in the following IDLE.
- SAVE_TIMEOUT=16, mem_done_saving stuck 0 -> save_done and save_err pulse exactly 16 cycles after SAVE_PULSE.
- rst asserted during ACCESS of a write -> mem_writeEnable and all outputs 0 before next edge, no rvalid. With DMA_ADDR_CHECK_EN, a read of 0x3C5B returns rdata=0 with addr_err=1.
